// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous shadow update.
// Optional decimal point support is enabled by defining SEVEN_SEGMENT_DP_EN.
module seven_segment_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
`ifdef SEVEN_SEGMENT_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    seg_dp,
`endif
  output logic [NUM_DIGITS-1:0]   seven_enable,
  output logic [6:0]              seg,
  output logic                    frame_done,
  output logic                    busy_pending
);

  localparam int CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SLOT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] val_pend_q, val_shad_q;
  logic [NUM_DIGITS-1:0]   blk_pend_q, blk_shad_q;
`ifdef SEVEN_SEGMENT_DP_EN
  logic [NUM_DIGITS-1:0]   dp_pend_q, dp_shad_q;
  logic                    dp_cur;
  logic                    seg_dp_d;
`endif

  logic                  wrap, boundary, blank_phase, blk_cur;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] en_sel, en_d;
  logic [6:0]            seg_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0001100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      4'hF: decode = 7'b0111000;
    endcase
  endfunction

  assign wrap        = (cnt_q == CntLast);
  assign boundary    = wrap && (idx_q == IdxLast);
  assign blank_phase = int'(cnt_q) < BLANK_CYCLES;

  always_comb begin
    nib     = 4'h0;
    blk_cur = 1'b0;
    en_sel  = '1;
`ifdef SEVEN_SEGMENT_DP_EN
    dp_cur  = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib       = val_shad_q[4*i +: 4];
        blk_cur   = blk_shad_q[i];
        en_sel[i] = 1'b0;
`ifdef SEVEN_SEGMENT_DP_EN
        dp_cur    = dp_shad_q[i];
`endif
      end
    end
  end

  always_comb begin
    en_d  = '1;
    seg_d = 7'b1111111;
`ifdef SEVEN_SEGMENT_DP_EN
    seg_dp_d = 1'b1;
`endif
    if (!blank_phase) begin
      en_d  = blk_cur ? '1 : en_sel;
      seg_d = decode(nib);
`ifdef SEVEN_SEGMENT_DP_EN
      seg_dp_d = blk_cur ? 1'b1 : ~dp_cur;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      val_pend_q   <= '0;
      val_shad_q   <= '0;
      blk_pend_q   <= '0;
      blk_shad_q   <= '0;
      busy_pending <= 1'b0;
      seven_enable <= '1;
      seg          <= 7'b1111111;
      frame_done   <= 1'b0;
`ifdef SEVEN_SEGMENT_DP_EN
      dp_pend_q    <= '0;
      dp_shad_q    <= '0;
      seg_dp       <= 1'b1;
`endif
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
      // Boundary moves the older pending data; a same-cycle load refills pending.
      if (boundary && busy_pending) begin
        val_shad_q <= val_pend_q;
        blk_shad_q <= blk_pend_q;
`ifdef SEVEN_SEGMENT_DP_EN
        dp_shad_q  <= dp_pend_q;
`endif
      end
      if (load) begin
        val_pend_q   <= value;
        blk_pend_q   <= blank;
        busy_pending <= 1'b1;
`ifdef SEVEN_SEGMENT_DP_EN
        dp_pend_q    <= dp;
`endif
      end else if (boundary) begin
        busy_pending <= 1'b0;
      end
      seven_enable <= en_d;
      seg          <= seg_d;
      frame_done   <= boundary;
`ifdef SEVEN_SEGMENT_DP_EN
      seg_dp       <= seg_dp_d;
`endif
    end
  end

endmodule
